// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional signed support is selected with the MULDIV_SIGNED_EN macro
// (see muldiv_unit.sv).
package muldiv_pkg;

  // Operand/result width; only 32 is supported.
  localparam int XLEN     = 32;
  // Iteration counter width, log2(XLEN).
  localparam int CNT_W    = 5;
  // Bit range of one architectural word.
  localparam int WORD_MSB = XLEN - 1;
  localparam int WORD_LSB = 0;
  // Bytes per architectural word.
  localparam int B_WORD   = XLEN / 8;

  typedef logic [WORD_MSB:WORD_LSB] word_t;
  typedef logic [2*XLEN-1:0]        dword_t;

  // Operation encodings as driven on op.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ITER = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  // Two's-complement negate a word when neg is set.
  function automatic word_t neg_if(input word_t v, input logic neg);
    return neg ? (~v + word_t'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// 64-bit accumulator/remainder register and the radix-2 iteration step.
// Multiply: shift-add, product builds up in acc (multiplier starts in the
// low half and is shifted out as product bits shift in).
// Divide: restoring division, remainder in the high half and quotient
// bits shifting into the low half.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic   clk_cpu,
  input  logic   reset,
  input  logic   load_i,    // capture operand magnitudes, clear accumulator
  input  logic   step_i,    // perform one iteration
  input  logic   is_div_i,  // 1: restoring-divide step, 0: shift-add step
  input  word_t  a_i,       // multiplier / dividend magnitude
  input  word_t  b_i,       // multiplicand / divisor magnitude
  output dword_t acc_o
);

  dword_t        acc_q, acc_d;
  word_t         b_q, b_d;
  logic [XLEN:0]   mul_sum;   // high half plus optional multiplicand, with carry
  logic [XLEN:0]   rem_sh;    // remainder shifted left with next dividend bit
  logic [XLEN+1:0] rem_diff;  // trial subtraction, MSB is the borrow
  logic            rem_ge;

  // Next accumulator value for load, iterate or hold.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    acc_d    = acc_q;
    b_d      = b_q;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
    rem_ge   = ~rem_diff[XLEN+1];

    if (load_i) begin
      acc_d = {word_t'(0), a_i};
      b_d   = b_i;
    end else if (step_i) begin
      if (is_div_i) begin
        // A remainder that cannot take the divisor is below it, so it fits
        // in XLEN bits and dropping rem_sh's top bit loses nothing.
        acc_d = rem_ge ? {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                       : {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk_cpu or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from before the clock edge.
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO.
// IDLE accepts start (or MTHI/MTLO writes), ITER runs 32 radix-2 steps,
// FIX applies sign correction and writes HI/LO with a one-cycle done.
// Define MULDIV_SIGNED_EN to build signed MULT/DIV (op[0]=0); without it
// every operation is unsigned and the sign logic is not built.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi_en,
  input  logic        mtlo_en,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            hi_q, hi_d;
  word_t            lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_div_q, is_div_d;
  logic             b_zero_q, b_zero_d;

  logic             dp_load;
  logic             dp_step;
  word_t            a_mag;
  word_t            b_mag;
  dword_t           acc;
  dword_t           mul_res;
  word_t            quot;
  word_t            rem;

`ifdef MULDIV_SIGNED_EN
  logic             signed_op;
  logic             neg_q, neg_d;        // operand signs differ
  logic             sign_a_q, sign_a_d;  // dividend sign, for the remainder

  assign signed_op = ~op[0];
`else
  logic             unused_op0;

  assign unused_op0 = op[0];
`endif

  muldiv_datapath u_datapath (
    .clk_cpu  (clk_cpu),
    .reset    (reset),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .is_div_i (is_div_q),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .acc_o    (acc)
  );

  // Sequencer next state, operand capture, result fix-up and HI/LO writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    a_mag    = src_a;
    b_mag    = src_b;
    mul_res  = acc;
    quot     = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
`ifdef MULDIV_SIGNED_EN
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    a_mag    = neg_if(src_a, signed_op & src_a[XLEN-1]);
    b_mag    = neg_if(src_b, signed_op & src_b[XLEN-1]);
    mul_res  = neg_q ? (~acc + dword_t'(1)) : acc;
    quot     = neg_if(acc[XLEN-1:0], neg_q);
    // Remainder takes the dividend's sign; for a zero divisor the magnitude
    // is |src_a|, so this restores src_a itself.
    rem      = neg_if(acc[2*XLEN-1:XLEN], sign_a_q);
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Start wins over any MTHI/MTLO in the same cycle.
          dp_load  = 1'b1;
          cnt_d    = '0;
          is_div_d = op[1];
          b_zero_d = (src_b == '0);
`ifdef MULDIV_SIGNED_EN
          neg_d    = signed_op & (src_a[XLEN-1] ^ src_b[XLEN-1]);
          sign_a_d = signed_op & src_a[XLEN-1];
`endif
          state_d  = S_ITER;
        end else begin
          if (mthi_en) hi_d = src_a;
          if (mtlo_en) lo_d = src_a;
        end
      end

      S_ITER: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          // Divide by zero returns all ones; the restoring steps already
          // leave the dividend as the remainder.
          lo_d = b_zero_q ? '1 : quot;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = mul_res;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and architectural registers.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Sign flags captured at start.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
    end else begin
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
    end
  end
`endif

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes the hand-computed
// HI/LO for each operation; a monitor pops and compares on every done.
module tb_muldiv_unit;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi_en;
  logic        mtlo_en;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks      = 0;
  int   n_pass        = 0;
  int   done_seen     = 0;
  int   done_expected = 0;
  int   op_id         = 0;

  muldiv_unit dut (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .mthi_en (mthi_en),
    .mtlo_en (mtlo_en),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk_cpu) begin
    if (!reset && done) begin
      done_seen++;
      check("sb_pending", {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check($sformatf("op%0d_hi", mon_e.id), hi, mon_e.hi);
        check($sformatf("op%0d_lo", mon_e.id), lo, mon_e.lo);
      end
    end
  end

  // Issue one operation, optionally disturbed mid-flight or with MTHI in
  // the start cycle, and check its timing; results go via the scoreboard.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit disturb, input bit with_mthi);
    logic [31:0] hi_before;
    int          cycles;
    int          busy_cycles;
    bit          got;
    op_id++;
    @(negedge clk_cpu);
    op      = o;
    src_a   = a;
    src_b   = b;
    start   = 1'b1;
    mthi_en = with_mthi;
    hi_before = hi;
    sb_q.push_back('{id: op_id, hi: eh, lo: el});
    done_expected++;
    @(posedge clk_cpu);
    #1;
    start   = 1'b0;
    mthi_en = 1'b0;
    src_a   = 32'h5A5A_1234;
    src_b   = 32'h0F0F_0F0F;
    if (with_mthi) check($sformatf("op%0d_mthi_dropped", op_id), hi, hi_before);
    cycles      = 0;
    busy_cycles = 0;
    got         = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk_cpu);
      cycles++;
      if (busy) busy_cycles++;
      if (done) got = 1'b1;
      if (disturb && cycles == 5) begin
        start   = 1'b1;
        mthi_en = 1'b1;
        src_a   = 32'hAAAA_5555;
      end else if (disturb && cycles == 6) begin
        start   = 1'b0;
        mthi_en = 1'b0;
      end
    end
    check($sformatf("op%0d_latency", op_id), cycles, 34);
    check($sformatf("op%0d_busy_cycles", op_id), busy_cycles, 33);
    @(negedge clk_cpu);
    check($sformatf("op%0d_done_width", op_id), {31'b0, done}, 32'd0);
    check($sformatf("op%0d_idle_after", op_id), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    src_a   = '0;
    src_b   = '0;
    mthi_en = 1'b0;
    mtlo_en = 1'b0;
    repeat (2) @(negedge clk_cpu);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;

    // MTLO in IDLE: LO updates at the next edge, HI untouched.
    @(negedge clk_cpu);
    src_a   = 32'hDEAD_BEEF;
    mtlo_en = 1'b1;
    @(negedge clk_cpu);
    mtlo_en = 1'b0;
    check("mtlo_lo", lo, 32'hDEAD_BEEF);
    check("mtlo_hi", hi, 32'h0);

    // MTHI in IDLE so HI is nonzero before the reset test.
    src_a   = 32'h1234_5678;
    mthi_en = 1'b1;
    @(negedge clk_cpu);
    mthi_en = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'hDEAD_BEEF);

    // Reset during iteration 10 of a MULTU aborts it with no HI/LO update.
    op    = 2'b01;
    src_a = 32'hFFFF_FFFF;
    src_b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk_cpu);
    #1 start = 1'b0;
    repeat (10) @(posedge clk_cpu);
    #1 reset = 1'b1;
    #2;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk_cpu);
    reset = 1'b0;

    // Unsigned operations.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op(2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0);
    run_op(2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b11, 32'd7,         32'd100,       32'd7,         32'd0,         1'b0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);

    // Signed op encodings; results depend on whether signed support is built.
`ifdef MULDIV_SIGNED_EN
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, 1'b0);
`else
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 1'b0);
`endif
    // Divide by zero returns src_a in HI in both builds.
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // start and mthi_en pulsed mid-operation are ignored.
    run_op(2'b01, 32'd6,         32'd7,         32'd0,         32'd42,        1'b1, 1'b0);
    // start and mthi_en together in IDLE: the operation runs, MTHI dropped.
    run_op(2'b01, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 1'b1);

    repeat (2) @(negedge clk_cpu);
    check("done_count", done_seen, done_expected);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
